aes_inv_cipher_top: RTL and testbench

Iterative AES-128 decryption core: the receive-side counterpart of `aes_cipher_top`. It accepts a 128-bit key and a 128-bit ciphertext block and returns plaintext after a fixed 10-cycle round loop. The key schedule is generated on the fly, using one cycle per round key in a one-time key-preparation pass. Ciphertext produced by `aes_cipher_top` under the same key decrypts to the original plaintext.

---
 rtl/aes_inv_cipher_top.sv | 275 +++++++++++++++++++++++++++
 tb/tb_aes_inv_cipher_top.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 inverse cipher: a one-time 10-cycle forward key expansion
// finds the last round key, then each block is decrypted in 10 round cycles.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] m, input logic [7:0] n);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = m;
        for (int i = 0; i < 8; i++) begin
            if (n[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as v^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] v);
        logic [7:0] p;
        logic [7:0] r;
        p = v;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] b;

    assign b = gf_inv(a);
    assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] m, input logic [7:0] n);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = m;
        for (int i = 0; i < 8; i++) begin
            if (n[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] v);
        logic [7:0] p;
        logic [7:0] r;
        p = v;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] b;

    // Undo the affine transform first, then invert in GF(2^8).
    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = gf_inv(b);
endmodule

module aes_inv_cipher_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic         kdone,
    output logic         done,
    output logic [127:0] text_out
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   kreg_q, kreg_d;
    logic [127:0]   klast_q, klast_d;
    logic           key_valid_q, key_valid_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   st_q, st_d;
    logic [127:0]   rk_q, rk_d;
    logic [127:0]   text_out_q, text_out_d;
    logic           done_q, done_d;
    logic           kdone_q, kdone_d;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] m, input logic [7:0] n);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = m;
        for (int i = 0; i < 8; i++) begin
            if (n[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127 - 32*c -: 8];
            a1 = v[119 - 32*c -: 8];
            a2 = v[111 - 32*c -: 8];
            a3 = v[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Shared SubWord: forward expansion in KEXP, reverse step otherwise.
    logic [127:0] pk;
    logic [31:0]  p3, sw_src, sw_rot, sub_word, t_word;
    logic [127:0] kfwd, kprev;
    logic [127:0] isb_out, x_blk, imix;

    assign pk       = (state_q == DEC) ? rk_q : klast_q;
    assign p3       = pk[31:0] ^ pk[63:32];
    assign sw_src   = (state_q == KEXP) ? kreg_q[31:0] : p3;
    assign sw_rot   = {sw_src[23:0], sw_src[31:24]};
    assign t_word   = sub_word ^ {rcon((state_q == IDLE) ? 4'd10 : rnd_q), 24'h000000};

    assign kfwd[127:96] = kreg_q[127:96] ^ t_word;
    assign kfwd[95:64]  = kreg_q[95:64] ^ kfwd[127:96];
    assign kfwd[63:32]  = kreg_q[63:32] ^ kfwd[95:64];
    assign kfwd[31:0]   = kreg_q[31:0] ^ kfwd[63:32];

    assign kprev = {pk[127:96] ^ t_word, pk[95:64] ^ pk[127:96], pk[63:32] ^ pk[95:64], p3};

    for (genvar j = 0; j < 4; j++) begin : g_ksb
        aes_sbox u_sbox (
            .a (sw_rot[31 - 8*j -: 8]),
            .y (sub_word[31 - 8*j -: 8])
        );
    end

    // InvShiftRows is pure wiring: output (row r, col c) reads column c-r.
    for (genvar i = 0; i < 16; i++) begin : g_isb
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = 4 * ((C - R + 4) % 4) + R;
        aes_inv_sbox u_inv_sbox (
            .a (st_q[127 - 8*SRC -: 8]),
            .y (isb_out[127 - 8*i -: 8])
        );
    end

    assign x_blk = isb_out ^ rk_q;
    assign imix  = inv_mix_columns(x_blk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kreg_q      <= '0;
            klast_q     <= '0;
            key_valid_q <= 1'b0;
            rnd_q       <= 4'd0;
            st_q        <= '0;
            rk_q        <= '0;
            text_out_q  <= '0;
            done_q      <= 1'b0;
            kdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kreg_q      <= kreg_d;
            klast_q     <= klast_d;
            key_valid_q <= key_valid_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            text_out_q  <= text_out_d;
            done_q      <= done_d;
            kdone_q     <= kdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (kld)                    state_d = KEXP;
                else if (ld && key_valid_q) state_d = DEC;
            end
            KEXP:    if (rnd_q == 4'd10) state_d = IDLE;
            DEC:     if (rnd_q == 4'd0)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        kreg_d      = kreg_q;
        klast_d     = klast_q;
        key_valid_d = key_valid_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        rk_d        = rk_q;
        text_out_d  = text_out_q;
        done_d      = 1'b0;
        kdone_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (kld) begin
                    kreg_d      = key;
                    rnd_d       = 4'd1;
                    key_valid_d = 1'b0;
                end else if (ld && key_valid_q) begin
                    st_d  = text_in ^ klast_q;
                    rk_d  = kprev;
                    rnd_d = 4'd9;
                end
            end
            KEXP: begin
                kreg_d = kfwd;
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    klast_d     = kfwd;
                    key_valid_d = 1'b1;
                    kdone_d     = 1'b1;
                end
            end
            DEC: begin
                if (rnd_q != 4'd0) begin
                    st_d  = imix;
                    rk_d  = kprev;
                    rnd_d = rnd_q - 4'd1;
                end else begin
                    text_out_d = x_blk;
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign kdone    = kdone_q;
    assign done     = done_q;
    assign text_out = text_out_q;
endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: known-answer table, random blocks against a
// full-expansion AES model, and timing/guard/reset sequences.

module tb_aes_inv_cipher_top;
    logic         clk = 1'b0;
    logic         rst, kld, ld;
    logic [127:0] key, text_in;
    logic         kdone, done;
    logic [127:0] text_out;

    aes_inv_cipher_top dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .ld       (ld),
        .key      (key),
        .text_in  (text_in),
        .kdone    (kdone),
        .done     (done),
        .text_out (text_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: table S-box from the generator-3 walk, full key expansion.
    logic [7:0]  sb    [256];
    logic [7:0]  isb_t [256];
    logic [31:0] w     [44];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = xt(aa);
        end
        return r;
    endfunction

    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb_t[sb[i]] = 8'(i);
    endfunction

    function automatic void expand(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
    endfunction

    function automatic logic [127:0] rkey(input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = inv ? isb_t[v[127 - 8*i -: 8]] : sb[v[127 - 8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127 - 8*(4*c + r) -: 8] = v[127 - 8*(4*src + r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        cf[0] = inv ? 8'h0e : 8'h02;
        cf[1] = inv ? 8'h0b : 8'h03;
        cf[2] = inv ? 8'h0d : 8'h01;
        cf[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gm(cf[(j - r + 4) % 4], v[127 - 8*(4*c + j) -: 8]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [127:0] s;
        expand(k);
        s = pt ^ rkey(0);
        for (int r = 1; r < 10; r++) s = mix(shift_rows(sub_bytes(s, 0), 0), 0) ^ rkey(r);
        return shift_rows(sub_bytes(s, 0), 0) ^ rkey(10);
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [127:0] s;
        expand(k);
        s = ct ^ rkey(10);
        for (int r = 9; r >= 1; r--) s = mix(sub_bytes(shift_rows(s, 1), 1) ^ rkey(r), 1);
        return sub_bytes(shift_rows(s, 1), 1) ^ rkey(0);
    endfunction

    task automatic load_key(input logic [127:0] k, output int lat);
        @(negedge clk);
        kld = 1'b1;
        key = k;
        @(negedge clk);
        kld = 1'b0;
        key = ~k;
        lat = 0;
        while (!kdone && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic decrypt(input logic [127:0] ct, output logic [127:0] pt, output int lat);
        @(negedge clk);
        ld = 1'b1;
        text_in = ct;
        @(negedge clk);
        ld = 1'b0;
        text_in = ~ct;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        pt = text_out;
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] klast;
    } vec_t;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KL  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs [2];
        logic [127:0] pt, ct, k, got;
        int           lat, seen, kd_seen, early, kd_at;

        vecs[0] = '{name: "fips_b",  key: B_KEY, ct: B_CT, pt: B_PT, klast: B_KL};
        vecs[1] = '{name: "fips_c1", key: C_KEY, ct: C_CT, pt: C_PT,
                    klast: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        build_sbox();

        rst = 1'b1; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_done",      128'(done),            128'd0);
        chk("reset_kdone",     128'(kdone),           128'd0);
        chk("reset_text_out",  text_out,              128'd0);
        chk("reset_key_valid", 128'(dut.key_valid_q), 128'd0);
        rst = 1'b0;

        // ld before any key is loaded
        @(negedge clk);
        ld = 1'b1; text_in = B_CT;
        @(negedge clk);
        ld = 1'b0;
        count_done(15, seen);
        chk("ld_without_key", 128'(seen), 128'd0);

        for (int v = 0; v < 2; v++) begin
            load_key(vecs[v].key, lat);
            chk({vecs[v].name, "_kdone_lat"}, 128'(lat), 128'd10);
            chk({vecs[v].name, "_klast"}, dut.klast_q, vecs[v].klast);
            decrypt(vecs[v].ct, got, lat);
            chk({vecs[v].name, "_done_lat"}, 128'(lat), 128'd10);
            chk({vecs[v].name, "_pt"}, got, vecs[v].pt);
            @(negedge clk);
            chk({vecs[v].name, "_done_width"}, 128'(done), 128'd0);
        end

        // round trip through the encryption model
        k  = 128'hcafebabedeadbeefdeadbeef00000000;
        pt = 128'hbba47f76875f634a85d6fe52004297b4;
        ct = model_encrypt(k, pt);
        load_key(k, lat);
        decrypt(ct, got, lat);
        chk("round_trip_pt", got, pt);

        // back-to-back blocks, ld on the done cycle
        load_key(B_KEY, lat);
        @(negedge clk);
        ld = 1'b1; text_in = B_CT;
        @(negedge clk);
        ld = 1'b0;
        for (int b = 0; b < 3; b++) begin
            lat = 0;
            while (!done && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("b2b_gap_%0d", b), 128'(lat), 128'd10);
            chk($sformatf("b2b_pt_%0d", b), text_out, B_PT);
            if (b < 2) begin
                ld = 1'b1; text_in = B_CT;
                @(negedge clk);
                ld = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_done_low", 128'(done), 128'd0);

        // ld and kld during DEC are ignored
        @(negedge clk);
        ld = 1'b1; text_in = B_CT;
        @(negedge clk);
        ld = 1'b0;
        early = 0; kd_seen = 0;
        for (int j = 1; j <= 10; j++) begin
            ld  = (j - 1 == 3);
            kld = (j - 1 == 5);
            text_in = C_CT;
            key = C_KEY;
            @(negedge clk);
            if (kdone) kd_seen++;
            if (done && j != 10) early++;
        end
        ld = 1'b0; kld = 1'b0;
        chk("guard_dec_done", 128'(done), 128'd1);
        chk("guard_dec_pt", text_out, B_PT);
        chk("guard_dec_early", 128'(early), 128'd0);
        count_done(15, seen);
        chk("guard_dec_not_queued", 128'(seen + kd_seen), 128'd0);
        chk("guard_dec_klast", dut.klast_q, B_KL);

        // kld and ld on the same edge: kld wins
        @(negedge clk);
        kld = 1'b1; ld = 1'b1; key = C_KEY; text_in = B_CT;
        @(negedge clk);
        kld = 1'b0; ld = 1'b0;
        seen = 0; kd_at = -1;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            if (done) seen++;
            if (kdone && kd_at < 0) kd_at = j;
        end
        chk("same_edge_no_done", 128'(seen), 128'd0);
        chk("same_edge_kdone_at", 128'(kd_at), 128'd10);
        decrypt(C_CT, got, lat);
        chk("same_edge_new_key_pt", got, C_PT);

        // randomized blocks against the model
        for (int r = 0; r < 12; r++) begin
            k  = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct = model_encrypt(k, pt);
            load_key(k, lat);
            chk($sformatf("rand_klast_%0d", r), dut.klast_q, rkey(10));
            decrypt(ct, got, lat);
            chk($sformatf("rand_pt_%0d", r), got, pt);
            ct = {$urandom(), $urandom(), $urandom(), $urandom()};
            decrypt(ct, got, lat);
            chk($sformatf("rand_dec_%0d", r), got, model_decrypt(k, ct));
        end

        // reset in the middle of a block
        load_key(B_KEY, lat);
        decrypt(B_CT, got, lat);
        @(negedge clk);
        ld = 1'b1; text_in = B_CT;
        @(negedge clk);
        ld = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_done",      128'(done),            128'd0);
        chk("midrst_text_out",  text_out,              128'd0);
        chk("midrst_key_valid", 128'(dut.key_valid_q), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(12, seen);
        chk("midrst_aborted", 128'(seen), 128'd0);
        @(negedge clk);
        ld = 1'b1; text_in = B_CT;
        @(negedge clk);
        ld = 1'b0;
        count_done(15, seen);
        chk("midrst_ld_ignored", 128'(seen), 128'd0);
        load_key(B_KEY, lat);
        chk("midrst_kdone_lat", 128'(lat), 128'd10);
        decrypt(B_CT, got, lat);
        chk("midrst_recover_pt", got, B_PT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
